// File: rtl/vector_point_sequencer.sv
// Vector display point sequencer: feeds destinations to a Bresenham line
// engine, single-steps it, and writes every visited pixel to a dual-channel
// SPI DAC (X on chan A, Y on chan B) followed by a shared LDAC pulse.
module vector_point_sequencer #(
  parameter int BITS         = 12,
  parameter int LDAC_CYCLES  = 2,
  parameter int DWELL_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [BITS-1:0] cmd_x,
  input  logic [BITS-1:0] cmd_y,
  input  logic            cmd_blank,
  output logic            line_strobe,
  output logic [BITS-1:0] line_x_in,
  output logic [BITS-1:0] line_y_in,
  input  logic            line_ready,
  input  logic [BITS-1:0] line_x_out,
  input  logic [BITS-1:0] line_y_out,
  output logic [11:0]     dac_value,
  output logic            dac_axis,
  output logic            dac_strobe,
  input  logic            dac_ready,
  output logic            ldac_n,
  output logic            beam_on,
  output logic            busy
);

  typedef enum logic [3:0] {
    IDLE, START, SEND_X, GUARD_X, WAIT_X, SEND_Y, GUARD_Y, WAIT_Y, LATCH, STEP, DWELL
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] LDAC_LAST  = CW'(LDAC_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

  state_t          state, state_nx;
  logic [BITS-1:0] dst_x, dst_y, dst_x_nx, dst_y_nx;
  logic            blank_reg, blank_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [11:0]     dac_value_nx;
  logic            dac_axis_nx, dac_strobe_nx, ldac_n_nx;

  // DAC words are always 12 bits; narrower coordinates sit in the low bits.
  function automatic logic [11:0] zext(input logic [BITS-1:0] v);
    zext = 12'(v);
  endfunction

  // Outputs that are pure decodes of the current state.
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign line_strobe = (state != STEP);
  assign beam_on     = (state != IDLE) && !blank_reg;
  assign line_x_in   = dst_x;
  assign line_y_in   = dst_y;

  // State and registered outputs; everything returns to idle values on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dst_x      <= '0;
      dst_y      <= '0;
      blank_reg  <= 1'b1;
      cnt        <= '0;
      dac_value  <= '0;
      dac_axis   <= 1'b0;
      dac_strobe <= 1'b0;
      ldac_n     <= 1'b1;
    end else begin
      state      <= state_nx;
      dst_x      <= dst_x_nx;
      dst_y      <= dst_y_nx;
      blank_reg  <= blank_nx;
      cnt        <= cnt_nx;
      dac_value  <= dac_value_nx;
      dac_axis   <= dac_axis_nx;
      dac_strobe <= dac_strobe_nx;
      ldac_n     <= ldac_n_nx;
    end
  end

  // Next-state and next-output logic for the point/DAC/LDAC sequence.
  always_comb begin
    state_nx      = state;
    dst_x_nx      = dst_x;
    dst_y_nx      = dst_y;
    blank_nx      = blank_reg;
    cnt_nx        = cnt;
    dac_value_nx  = dac_value;
    dac_axis_nx   = dac_axis;
    dac_strobe_nx = 1'b0;
    ldac_n_nx     = 1'b1;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dst_x_nx = cmd_x;
          dst_y_nx = cmd_y;
          blank_nx = cmd_blank;
          state_nx = START;
        end
      end
      START: state_nx = SEND_X;
      SEND_X: begin
        if (dac_ready) begin
          dac_strobe_nx = 1'b1;
          dac_axis_nx   = 1'b0;
          dac_value_nx  = zext(line_x_out);
          state_nx      = GUARD_X;
        end
      end
      // The driver drops dac_ready only after it has seen the strobe.
      GUARD_X: state_nx = WAIT_X;
      WAIT_X:  if (dac_ready) state_nx = SEND_Y;
      SEND_Y: begin
        if (dac_ready) begin
          dac_strobe_nx = 1'b1;
          dac_axis_nx   = 1'b1;
          dac_value_nx  = zext(line_y_out);
          state_nx      = GUARD_Y;
        end
      end
      GUARD_Y: state_nx = WAIT_Y;
      WAIT_Y: begin
        if (dac_ready) begin
          ldac_n_nx = 1'b0;
          cnt_nx    = '0;
          state_nx  = LATCH;
        end
      end
      LATCH: begin
        if (cnt == LDAC_LAST) begin
          cnt_nx = '0;
          if (!line_ready)            state_nx = STEP;
          else if (DWELL_CYCLES == 0) state_nx = IDLE;
          else                        state_nx = DWELL;
        end else begin
          ldac_n_nx = 1'b0;
          cnt_nx    = cnt + CW'(1);
        end
      end
      // Strobe low for this one cycle lets the engine advance one pixel.
      STEP: state_nx = SEND_X;
      DWELL: begin
        if (cnt == DWELL_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_point_sequencer.sv
// Directed bench for vector_point_sequencer with a behavioural Bresenham
// line engine and a simple DAC driver model.
module tb_vector_point_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_blank;
  logic [11:0] cmd_x, cmd_y;
  logic        line_strobe, line_ready;
  logic [11:0] line_x_in, line_y_in, line_x_out, line_y_out;
  logic [11:0] dac_value;
  logic        dac_axis, dac_strobe, dac_ready;
  logic        ldac_n, beam_on, busy;

  vector_point_sequencer #(.BITS(12), .LDAC_CYCLES(2), .DWELL_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_blank(cmd_blank),
    .line_strobe(line_strobe), .line_x_in(line_x_in), .line_y_in(line_y_in),
    .line_ready(line_ready), .line_x_out(line_x_out), .line_y_out(line_y_out),
    .dac_value(dac_value), .dac_axis(dac_axis), .dac_strobe(dac_strobe),
    .dac_ready(dac_ready), .ldac_n(ldac_n), .beam_on(beam_on), .busy(busy)
  );

  always #5 clk = ~clk;

  // Line engine model: strobe high loads the target, strobe low takes one step.
  int   ex = 0, ey = 0, tx = 0, ty = 0;
  logic eng_set = 1'b0;
  int   set_x = 0, set_y = 0;
  always @(posedge clk) begin
    int dx, dy, sx, sy, e2;
    if (eng_set) begin
      ex <= set_x; ey <= set_y;
    end else if (line_strobe) begin
      tx <= int'(line_x_in); ty <= int'(line_y_in);
    end else if (!(ex == tx && ey == ty)) begin
      dx = (tx > ex) ? tx - ex : ex - tx;
      dy = (ty > ey) ? ty - ey : ey - ty;
      sx = (tx > ex) ? 1 : -1;
      sy = (ty > ey) ? 1 : -1;
      e2 = 2 * (dx - dy);
      if (e2 > -dy) ex <= ex + sx;
      if (e2 < dx)  ey <= ey + sy;
    end
  end
  assign line_x_out = 12'(ex);
  assign line_y_out = 12'(ey);
  assign line_ready = (ex == tx) && (ey == ty);

  // DAC driver model: busy for 3 cycles after each strobe.
  int   dcnt;
  logic dac_hold = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset)          dcnt <= 0;
    else if (dac_strobe) dcnt <= 3;
    else if (dcnt != 0)  dcnt <= dcnt - 1;
  end
  assign dac_ready = (dcnt == 0) && !dac_hold;

  // Monitor: records strobes, LDAC pulse widths, beam and busy activity.
  int   cyc = 0, run = 0, last_rise = 0, fall_cyc = 0;
  int   busy_cyc = 0, beam_cyc = 0, idle_beam = 0;
  logic prev_busy = 1'b0;
  int   sq_val[$];
  bit   sq_ax[$];
  int   lq[$];
  always @(posedge clk) begin
    #2;
    cyc++;
    if (dac_strobe) begin sq_val.push_back(int'(dac_value)); sq_ax.push_back(dac_axis); end
    if (ldac_n == 1'b0) run++;
    else if (run != 0) begin lq.push_back(run); run = 0; last_rise = cyc; end
    if (prev_busy && !busy) fall_cyc = cyc;
    prev_busy = busy;
    if (busy) begin busy_cyc++; if (beam_on) beam_cyc++; end
    else if (beam_on) idle_beam++;
  end

  int nchk = 0, npass = 0, nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string tag, input int base, input int i, input int xe, input int ye);
    check({tag, "_axx"}, 32'(sq_ax[base + 2*i]), 0);
    check({tag, "_x"},   32'(sq_val[base + 2*i]), 32'(xe));
    check({tag, "_axy"}, 32'(sq_ax[base + 2*i + 1]), 1);
    check({tag, "_y"},   32'(sq_val[base + 2*i + 1]), 32'(ye));
  endtask

  task automatic teleport(input int x, input int y);
    @(negedge clk); eng_set = 1'b1; set_x = x; set_y = y;
    @(negedge clk); eng_set = 1'b0;
  endtask

  task automatic send_cmd(input int x, input int y, input logic b);
    int t;
    @(negedge clk);
    cmd_x = 12'(x); cmd_y = 12'(y); cmd_blank = b; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    check({tag, "_done"}, 32'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int sb, lb, bb, mb, bad, s0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_blank = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(cmd_ready), 1);
    check("rst_busy",   32'(busy), 0);
    check("rst_lstrb",  32'(line_strobe), 1);
    check("rst_ldac",   32'(ldac_n), 1);
    check("rst_beam",   32'(beam_on), 0);
    check("rst_dstrb",  32'(dac_strobe), 0);
    check("rst_dval",   32'(dac_value), 0);
    check("rst_daxis",  32'(dac_axis), 0);
    check("rst_lxin",   32'(line_x_in), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: horizontal line (0,0)->(3,0), beam on
    sb = sq_val.size(); lb = lq.size(); bb = busy_cyc; mb = beam_cyc;
    send_cmd(3, 0, 1'b0);
    check("t1_lxin", 32'(line_x_in), 3);
    wait_done("t1");
    check("t1_nstrb", 32'(sq_val.size() - sb), 8);
    for (int i = 0; i < 4; i++) check_pair("t1_pair", sb, i, i, 0);
    check("t1_nldac", 32'(lq.size() - lb), 4);
    for (int i = 0; i < 4; i++) check("t1_ldacw", 32'(lq[lb + i]), 2);
    check("t1_beam", 32'(beam_cyc - mb), 32'(busy_cyc - bb));
    check("t1_dwell", 32'(fall_cyc - last_rise), 16);
    check("t1_ready", 32'(cmd_ready), 1);

    // 2: zero-length command draws one dot
    teleport(5, 5);
    sb = sq_val.size(); lb = lq.size();
    send_cmd(5, 5, 1'b0);
    wait_done("t2");
    check("t2_nstrb", 32'(sq_val.size() - sb), 2);
    check_pair("t2_pair", sb, 0, 5, 5);
    check("t2_nldac", 32'(lq.size() - lb), 1);
    check("t2_dwell", 32'(fall_cyc - last_rise), 16);

    // 3: diagonal (0,0)->(3,2)
    teleport(0, 0);
    sb = sq_val.size(); lb = lq.size();
    send_cmd(3, 2, 1'b0);
    wait_done("t3");
    check("t3_nstrb", 32'(sq_val.size() - sb), 8);
    check_pair("t3_p0", sb, 0, 0, 0);
    check_pair("t3_p1", sb, 1, 1, 1);
    check_pair("t3_p2", sb, 2, 2, 1);
    check_pair("t3_p3", sb, 3, 3, 2);
    check("t3_nldac", 32'(lq.size() - lb), 4);

    // 4: DAC busy for 40 cycles in SEND_X
    teleport(0, 0);
    dac_hold = 1'b1;
    sb = sq_val.size();
    send_cmd(1, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dac_strobe || !line_strobe || line_x_out != 12'd0 || !busy) bad++;
    end
    check("t4_stall", 32'(bad), 0);
    check("t4_nostrb", 32'(sq_val.size() - sb), 0);
    dac_hold = 1'b0;
    wait_done("t4");
    check("t4_nstrb", 32'(sq_val.size() - sb), 4);
    check_pair("t4_p0", sb, 0, 0, 0);
    check_pair("t4_p1", sb, 1, 1, 0);

    // 5: blanked traverse (0,0)->(2,0)
    teleport(0, 0);
    sb = sq_val.size(); mb = beam_cyc;
    send_cmd(2, 0, 1'b1);
    wait_done("t5");
    check("t5_beam", 32'(beam_cyc - mb), 0);
    check("t5_nstrb", 32'(sq_val.size() - sb), 6);
    for (int i = 0; i < 3; i++) check_pair("t5_pair", sb, i, i, 0);

    // 6: reset during WAIT_Y of the second pixel
    teleport(0, 0);
    send_cmd(3, 0, 1'b0);
    s0 = 0;
    for (int t = 0; t < 500 && s0 < 4; t++) begin
      if (dac_strobe) s0++;
      if (s0 < 4) @(negedge clk);
    end
    check("t6_reach", 32'(s0), 4);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("t6_busy",  32'(busy), 0);
    check("t6_ldac",  32'(ldac_n), 1);
    check("t6_beam",  32'(beam_on), 0);
    check("t6_lstrb", 32'(line_strobe), 1);
    check("t6_dstrb", 32'(dac_strobe), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(cmd_ready), 1);
    teleport(0, 0);
    sb = sq_val.size();
    send_cmd(0, 1, 1'b0);
    wait_done("t6");
    check("t6_nstrb", 32'(sq_val.size() - sb), 4);
    check_pair("t6_p0", sb, 0, 0, 0);
    check_pair("t6_p1", sb, 1, 0, 1);

    check("idle_beam", 32'(idle_beam), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/vector_point_sequencer.md
Name: vector_point_sequencer

Overview:
- Sequences one Bresenham line engine and one dual-channel SPI DAC driver (MCP4922) for the vector display path.
- Accepts point commands (x, y, blank) over a valid/ready handshake and loads each destination into the line engine.
- Stalls the line engine after every one-pixel step, writes the X then Y position to the DAC, and pulses LDAC so both channels update together.
- Drives the beam-enable output and a per-point dwell.

Parameters:
- BITS, 12, coordinate width; must be ≤ 12 (DAC value width).
- LDAC_CYCLES, 2, width in clk cycles of the active-low LDAC pulse (≥ 1).
- DWELL_CYCLES, 16, idle cycles after a command's final point is latched, beam state held (0 = no dwell).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_x  in  BITS  destination X
- cmd_y  in  BITS  destination Y
- cmd_blank  in  1  1 = traverse with beam off
- line_strobe  out  1  to line engine strobe; high = load/hold, low = allow one step
- line_x_in  out  BITS  to line engine destination X
- line_y_in  out  BITS  to line engine destination Y
- line_ready  in  1  line engine at destination
- line_x_out  in  BITS  line engine current X
- line_y_out  in  BITS  line engine current Y
- dac_value  out  12  to DAC driver value, zero-extended position
- dac_axis  out  1  to DAC driver axis; 0 = X (chan A), 1 = Y (chan B)
- dac_strobe  out  1  to DAC driver strobe, single-cycle
- dac_ready  in  1  DAC driver idle
- ldac_n  out  1  DAC latch, active low
- beam_on  out  1  Z/beam enable
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; dst_x/dst_y=0; blank_reg=1; line_strobe=1; dac_strobe=0; dac_axis=0; dac_value=0; ldac_n=1; beam_on=0; all counters 0.
- line_x_in/line_y_in are driven from dst_x/dst_y at all times.
- line_strobe=1 in every state except STEP. Holding the strobe with an unchanged destination freezes the engine and reloads its error term. Each step restarts Bresenham from the current pixel; the path stays within 1 LSB of the ideal line and always terminates at the destination.
- cmd_ready = (state==IDLE). On cmd_valid&&cmd_ready: latch cmd_x→dst_x, cmd_y→dst_y, cmd_blank→blank_reg; next state START.
- A cmd_valid arriving in any other state is ignored (not latched) until IDLE.
- FSM:
  - IDLE: wait for command.
  - START: 1 cycle; the engine loads the new destination. → SEND_X.
  - SEND_X: when dac_ready=1, assert dac_strobe for 1 cycle with dac_axis=0, dac_value=line_x_out. → GUARD_X. While dac_ready=0, stay and keep dac_strobe=0.
  - GUARD_X: 1 cycle; dac_ready is ignored (the driver deasserts it one cycle after strobe). → WAIT_X.
  - WAIT_X: stay until dac_ready=1. → SEND_Y.
  - SEND_Y / GUARD_Y / WAIT_Y: same as the X states with dac_axis=1, dac_value=line_y_out. → LATCH.
  - LATCH: ldac_n=0 for exactly LDAC_CYCLES cycles, then ldac_n=1. If line_ready=1 → DWELL (or IDLE if DWELL_CYCLES=0), else → STEP.
  - STEP: line_strobe=0 for exactly 1 cycle; the engine moves one pixel. → SEND_X. The sampled line_x_out/line_y_out are the post-step values, registered in SEND_X.
  - DWELL: count DWELL_CYCLES cycles. → IDLE.
- The first DAC pair per command is the starting point, so a zero-length command draws a dot: exactly one X/Y pair and one LDAC pulse.
- A line of N pixel steps produces N+1 X/Y pairs and N+1 LDAC pulses.
- beam_on = ~blank_reg from the START cycle through the last DWELL cycle; 0 in IDLE.
  - Blanked commands traverse identically with beam_on=0.
- dac_value and dac_axis are held between strobes.
- Reset mid-command: immediate return to reset values, and any in-flight DAC transfer is abandoned. The DAC driver's own reset is the system's responsibility.

Test Plan:
1. Line engine at (0,0); cmd (3,0,blank=0) → 4 pairs with X=0,1,2,3, Y=0 each; 4 ldac_n pulses, each 2 cycles wide; beam_on=1 throughout; busy falls and cmd_ready rises 16 cycles after the last LDAC.
2. Zero-length cmd to the current point (5,5) → exactly one X=5/Y=5 pair, one LDAC pulse, then DWELL → IDLE.
3. Diagonal (0,0)→(3,2) → final pair (3,2); each successive pair differs by ≤1 in each axis; total pairs = pixel steps+1.
4. dac_ready held low 40 cycles during SEND_X → no dac_strobe, line_strobe stays 1, and line_x_out is unchanged; on release, exactly one strobe with axis=0.
5. cmd_blank=1 line (0,0)→(2,0) → beam_on=0 for the whole command; DAC pairs still emitted for X=0,1,2.
6. Assert reset during WAIT_Y of the second pixel → next cycle: IDLE, ldac_n=1, beam_on=0, line_strobe=1, cmd_ready=1 after release; a new command is then accepted normally.
